// File: rtl/display_share_arbiter.sv
// rtl/display_share_arbiter.sv - round-robin owner arbitration for the shared 4-digit display
module display_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 400_000,
  parameter int CNT_W       = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [15:0]           disp_data,
  output logic                  disp_blank,
  output logic                  busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = PW + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      ptr, ptr_n;
  logic [PW-1:0]      own, own_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N_REQ-1:0]   grant_n, done_n;
  logic [15:0]        data_n;
  logic               blank_n, busy_n;

  logic [PW-1:0]      win;
  logic [IW-1:0]      idx;
  logic               found;
  logic [15:0]        win_data;
  logic               own_req;
  logic [N_REQ-1:0]   win_onehot;

  // Circular search for the first active request starting at ptr.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    own_req  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win == PW'(j)) win_data = req_data[16*j +: 16];
      if (own == PW'(j)) own_req  = req[j];
    end
  end

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win;

  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    data_n  = disp_data;
    blank_n = disp_blank;
    busy_n  = busy;
    ptr_n   = ptr;
    own_n   = own;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = SHOW;
          grant_n = win_onehot;
          data_n  = win_data;
          blank_n = 1'b0;
          busy_n  = 1'b1;
          own_n   = win;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        // Timeout wins over a simultaneous release so the owner still sees done.
        if (cnt == HOLD_LAST || !own_req) begin
          if (cnt == HOLD_LAST) done_n = grant;
          grant_n = '0;
          blank_n = 1'b1;
          ptr_n   = (own == PW'(N_REQ - 1)) ? '0 : own + PW'(1);
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        blank_n = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      disp_data  <= 16'h0000;
      disp_blank <= 1'b1;
      busy       <= 1'b0;
      ptr        <= '0;
      own        <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      done       <= done_n;
      disp_data  <= data_n;
      disp_blank <= blank_n;
      busy       <= busy_n;
      ptr        <= ptr_n;
      own        <= own_n;
      cnt        <= cnt_n;
    end
  end

endmodule
